// File: rtl/nn_params_pkg.sv
// Shared layer parameters and stage state encodings for the NN datapath.
// Every layer memory and stage imports this package.
package nn_params_pkg;

  localparam int NN_N_ELEM  = 64;
  localparam int NN_DATA_W  = 32;
  localparam int NN_ADDR_W  = 16;
  localparam int NN_COUNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/relu_cell.sv
// Combinational ReLU on a signed two's-complement word.
// Kept standalone so later layers can reuse it.
module relu_cell
  import nn_params_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  logic pos_s;

  assign pos_s = ~x[DATA_W-1] & (|x);

  // Pass strictly positive values, clamp zero and negatives to zero
  always_comb begin
    if (pos_s) begin
      y = x;
    end else begin
      y = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/relu1_stage.sv
// Layer-1 activation stage: streams N_ELEM words from the layer-1 result memory
// through relu_cell into the activation memory at one element per cycle.
module relu1_stage
  import nn_params_pkg::*;
#(
  parameter int N_ELEM = NN_N_ELEM,
  parameter int DATA_W = NN_DATA_W,
  parameter int ADDR_W = NN_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mm1_read_addr,
  input  logic [DATA_W-1:0]     mm1_data,
  output logic [ADDR_W-1:0]     relu_write_addr,
  output logic [DATA_W-1:0]     relu_data,
  output logic                  relu_write_enable,
  output logic [NN_COUNT_W-1:0] active_count
);

  localparam int                IDX_W    = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);

  stage_state_e          state_r;
  logic [IDX_W-1:0]      rd_idx_r;
  logic [IDX_W-1:0]      next_idx_s;
  logic                  last_s;
  logic [DATA_W-1:0]     relu_y_s;
  logic                  pos_s;
  logic                  busy_r;
  logic                  done_r;
  logic [ADDR_W-1:0]     rd_addr_r;
  logic [ADDR_W-1:0]     waddr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic                  valid_r;
  logic [NN_COUNT_W-1:0] run_count_r;
  logic [NN_COUNT_W-1:0] active_count_r;

  relu_cell #(.DATA_W(DATA_W)) u_relu_cell (
    .x (mm1_data),
    .y (relu_y_s)
  );

  assign next_idx_s = rd_idx_r + IDX_W'(1);
  assign last_s     = (rd_idx_r == LAST_IDX);
  // A nonzero ReLU result is exactly the strictly-positive case
  assign pos_s      = |relu_y_s;

  assign busy              = busy_r;
  assign done              = done_r;
  assign mm1_read_addr     = rd_addr_r;
  assign relu_write_addr   = waddr_r;
  assign relu_data         = wdata_r;
  assign relu_write_enable = valid_r;
  assign active_count      = active_count_r;

  // Sequencer, stage register and counters; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      rd_idx_r       <= {IDX_W{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      rd_addr_r      <= {ADDR_W{1'b0}};
      waddr_r        <= {ADDR_W{1'b0}};
      wdata_r        <= {DATA_W{1'b0}};
      valid_r        <= 1'b0;
      run_count_r    <= {NN_COUNT_W{1'b0}};
      active_count_r <= {NN_COUNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r   <= 1'b0;
          done_r    <= 1'b0;
          rd_addr_r <= {ADDR_W{1'b0}};
          if (start) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b1;
            rd_idx_r    <= {IDX_W{1'b0}};
            run_count_r <= {NN_COUNT_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          waddr_r <= ADDR_W'(rd_idx_r);
          wdata_r <= relu_y_s;
          valid_r <= 1'b1;
          if (pos_s) begin
            run_count_r <= run_count_r + NN_COUNT_W'(1);
          end else begin
            run_count_r <= run_count_r;
          end
          // The read address runs one index ahead so it is valid the cycle it is used
          if (last_s) begin
            state_r   <= ST_FLUSH;
            rd_idx_r  <= {IDX_W{1'b0}};
            rd_addr_r <= {ADDR_W{1'b0}};
          end else begin
            state_r   <= ST_RUN;
            rd_idx_r  <= next_idx_s;
            rd_addr_r <= ADDR_W'(next_idx_s);
          end
        end
        ST_FLUSH: begin
          valid_r        <= 1'b0;
          done_r         <= 1'b1;
          active_count_r <= run_count_r;
          state_r        <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          valid_r   <= 1'b0;
          rd_addr_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu1_stage.sv
// Self-checking bench for relu1_stage: behavioural memory, write sink and a
// plain-arithmetic ReLU/count model; randomized vectors plus directed corners.
module tb_relu1_stage;

  localparam int N_ELEM = 64;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int BUDGET = 200;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mm1_read_addr;
  logic [DATA_W-1:0] mm1_data;
  logic [ADDR_W-1:0] relu_write_addr;
  logic [DATA_W-1:0] relu_data;
  logic              relu_write_enable;
  logic [6:0]        active_count;

  logic [DATA_W-1:0] mem     [N_ELEM];
  logic [DATA_W-1:0] wr_data [N_ELEM];
  int                wr_cyc  [N_ELEM];
  int                wr_hits [N_ELEM];
  int cyc = 0, wr_cnt = 0, done_cnt = 0, wr_in_done = 0, bad_addr = 0, e0_cyc = 0;
  int vectors = 0, miscompares = 0;

  relu1_stage dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mm1_read_addr     (mm1_read_addr),
    .mm1_data          (mm1_data),
    .relu_write_addr   (relu_write_addr),
    .relu_data         (relu_data),
    .relu_write_enable (relu_write_enable),
    .active_count      (active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mm1_data = mem[mm1_read_addr[5:0]];

  // Activation-memory sink: captures a write on the edge after the strobe
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (int'(mm1_read_addr) >= N_ELEM) bad_addr = bad_addr + 1;
    if (done) done_cnt = done_cnt + 1;
    if (relu_write_enable) begin
      wr_cnt = wr_cnt + 1;
      if (done) wr_in_done = wr_in_done + 1;
      if (int'(relu_write_addr) < N_ELEM) begin
        wr_data[relu_write_addr[5:0]] = relu_data;
        wr_cyc[relu_write_addr[5:0]]  = cyc;
        wr_hits[relu_write_addr[5:0]] = wr_hits[relu_write_addr[5:0]] + 1;
      end else begin
        bad_addr = bad_addr + 1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] ref_relu(input logic [DATA_W-1:0] x);
    return ($signed(x) > 0) ? x : {DATA_W{1'b0}};
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < N_ELEM; i++) if ($signed(mem[i]) > 0) c++;
    return c;
  endfunction

  task automatic clear_logs();
    for (int i = 0; i < N_ELEM; i++) begin
      wr_data[i] = {DATA_W{1'b0}};
      wr_cyc[i]  = 0;
      wr_hits[i] = 0;
    end
    wr_cnt = 0; done_cnt = 0; wr_in_done = 0; bad_addr = 0;
  endtask

  // Pulses start, optionally re-pulses it at cycle restart_at, waits for done
  task automatic run_vector(input int restart_at, output int lat, output bit got);
    clear_logs();
    got = 1'b0;
    lat = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; e0_cyc = cyc; start = 1'b0;
    for (int n = 1; n <= BUDGET && !got; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      if (done) begin
        got = 1'b1;
        lat = n - 1;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, relu_write_enable, relu_write_addr, relu_data, mm1_read_addr, active_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b waddr=%h data=%h raddr=%h cnt=%0d, expected all 0",
               busy, done, relu_write_enable, relu_write_addr, relu_data, mm1_read_addr, active_count);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_ramp();
    int lat; bit got;
    for (int k = 0; k < N_ELEM; k++) mem[k] = DATA_W'(k - 32);
    run_vector(-1, lat, got);
    vectors++;
    if (!got || lat != 65) begin
      miscompares++;
      $display("FAIL ramp_done_latency: got %0d (seen=%0d), expected 65", lat, got);
    end
    for (int k = 0; k < N_ELEM; k++) begin
      vectors++;
      if (wr_hits[k] != 1 || wr_data[k] !== ref_relu(mem[k])) begin
        miscompares++;
        $display("FAIL ramp_elem[%0d]: got %h x%0d, expected %h x1", k, wr_data[k], wr_hits[k], ref_relu(mem[k]));
      end
    end
    vectors++;
    if (wr_data[33] !== 32'd1 || wr_data[63] !== 32'd31 || wr_data[32] !== 32'd0) begin
      miscompares++;
      $display("FAIL ramp_spot: got [32]=%h [33]=%h [63]=%h, expected 0 1 1f", wr_data[32], wr_data[33], wr_data[63]);
    end
    vectors++;
    if (active_count !== 7'd31) begin
      miscompares++;
      $display("FAIL ramp_active_count: got %0d, expected 31", active_count);
    end
    vectors++;
    if (wr_cyc[0] != e0_cyc + 2 || wr_cyc[63] != e0_cyc + 65) begin
      miscompares++;
      $display("FAIL ramp_write_timing: got %0d/%0d, expected %0d/%0d",
               wr_cyc[0] - e0_cyc, wr_cyc[63] - e0_cyc, 2, 65);
    end
    vectors++;
    if (wr_cnt != N_ELEM || wr_in_done != 0 || bad_addr != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_protocol: writes=%0d in_done=%0d bad_addr=%0d busy=%b, expected 64 0 0 0",
               wr_cnt, wr_in_done, bad_addr, busy);
    end
  endtask

  task automatic test_boundary();
    int lat; bit got;
    logic [DATA_W-1:0] pat [3];
    pat[0] = 32'h8000_0000; pat[1] = 32'h7FFF_FFFF; pat[2] = 32'h0000_0000;
    for (int k = 0; k < N_ELEM; k++) mem[k] = pat[k % 3];
    run_vector(-1, lat, got);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (wr_data[k] !== ((k == 1) ? 32'h7FFF_FFFF : 32'h0000_0000)) begin
        miscompares++;
        $display("FAIL boundary_elem[%0d]: got %h, expected %h", k, wr_data[k], ref_relu(pat[k]));
      end
    end
    vectors++;
    if (!got || active_count !== 7'd21 || wr_cnt != N_ELEM) begin
      miscompares++;
      $display("FAIL boundary_count: got cnt=%0d writes=%0d done=%0d, expected 21 64 1", active_count, wr_cnt, got);
    end
  endtask

  task automatic test_random();
    int lat; bit got;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N_ELEM; k++) begin
        case ($urandom_range(0, 5))
          0:       mem[k] = 32'h0000_0000;
          1:       mem[k] = 32'h8000_0000;
          2:       mem[k] = DATA_W'($urandom_range(0, 4)) - 32'd2;
          default: mem[k] = $urandom;
        endcase
      end
      run_vector(-1, lat, got);
      for (int k = 0; k < N_ELEM; k++) begin
        vectors++;
        if (wr_hits[k] != 1 || wr_data[k] !== ref_relu(mem[k])) begin
          miscompares++;
          $display("FAIL random%0d_elem[%0d]: got %h x%0d, expected %h x1", v, k, wr_data[k], wr_hits[k], ref_relu(mem[k]));
        end
      end
      vectors++;
      if (!got || lat != 65 || int'(active_count) != exp_count() || done_cnt != 1) begin
        miscompares++;
        $display("FAIL random%0d_summary: got cnt=%0d lat=%0d dones=%0d, expected %0d 65 1",
                 v, active_count, lat, done_cnt, exp_count());
      end
    end
  endtask

  task automatic test_restart_ignored();
    int lat; bit got;
    for (int k = 0; k < N_ELEM; k++) mem[k] = $urandom;
    run_vector(10, lat, got);
    vectors++;
    if (!got || lat != 65 || wr_cnt != N_ELEM || done_cnt != 1 || int'(active_count) != exp_count()) begin
      miscompares++;
      $display("FAIL restart_run: got writes=%0d dones=%0d lat=%0d cnt=%0d, expected 64 1 65 %0d",
               wr_cnt, done_cnt, lat, active_count, exp_count());
    end
    repeat (80) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_cnt != N_ELEM || done_cnt != 1) begin
      miscompares++;
      $display("FAIL restart_not_queued: got busy=%b writes=%0d dones=%0d, expected 0 64 1", busy, wr_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit got; int snap;
    for (int k = 0; k < N_ELEM; k++) mem[k] = DATA_W'(k + 1);
    run_vector(-1, lat, got);
    vectors++;
    if (active_count !== 7'd64) begin
      miscompares++;
      $display("FAIL midreset_precount: got %0d, expected 64", active_count);
    end
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1; snap = wr_cnt;
    @(negedge clk); reset = 1'b0;
    repeat (100) @(negedge clk);
    vectors++;
    if (snap != 19 || wr_cnt != snap) begin
      miscompares++;
      $display("FAIL midreset_writes: got %0d at reset, %0d later, expected 19 and 19", snap, wr_cnt);
    end
    vectors++;
    if (done_cnt != 0 || active_count !== 7'd0 || busy !== 1'b0 || mm1_read_addr !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset_state: got dones=%0d cnt=%0d busy=%b raddr=%h, expected 0 0 0 0",
               done_cnt, active_count, busy, mm1_read_addr);
    end
  endtask

  task automatic test_back_to_back();
    bit busy_h [200];
    bit done_h [200];
    bit idle;
    for (int k = 0; k < N_ELEM; k++) mem[k] = $urandom;
    clear_logs();
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      busy_h[i] = busy;
      done_h[i] = done;
    end
    start = 1'b0;
    idle = 1'b0;
    for (int n = 0; n < BUDGET && !idle; n++) begin
      @(negedge clk);
      idle = (busy === 1'b0);
    end
    vectors++;
    if (!idle || done_cnt < 2 || wr_cnt != N_ELEM * done_cnt || int'(active_count) != exp_count()) begin
      miscompares++;
      $display("FAIL b2b_runs: got idle=%0d dones=%0d writes=%0d cnt=%0d, expected 1 >=2 64*dones %0d",
               idle, done_cnt, wr_cnt, active_count, exp_count());
    end
    for (int k = 0; k < N_ELEM; k++) begin
      vectors++;
      if (wr_hits[k] != done_cnt || wr_data[k] !== ref_relu(mem[k])) begin
        miscompares++;
        $display("FAIL b2b_elem[%0d]: got %h x%0d, expected %h x%0d", k, wr_data[k], wr_hits[k], ref_relu(mem[k]), done_cnt);
      end
    end
    for (int i = 0; i + 2 < 200; i++) begin
      if (done_h[i]) begin
        vectors++;
        if (busy_h[i + 1] !== 1'b0 || done_h[i + 1] !== 1'b0 || busy_h[i + 2] !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_gap@%0d: got busy %b,%b done %b, expected busy 0,1 done 0",
                   i, busy_h[i + 1], busy_h[i + 2], done_h[i + 1]);
        end
      end
    end
  endtask

  task automatic test_all_negative();
    int lat; bit got;
    for (int k = 0; k < N_ELEM; k++) mem[k] = 32'h8000_0000 | $urandom;
    run_vector(-1, lat, got);
    for (int k = 0; k < N_ELEM; k++) begin
      vectors++;
      if (wr_hits[k] != 1 || wr_data[k] !== 32'h0000_0000) begin
        miscompares++;
        $display("FAIL neg_elem[%0d]: got %h x%0d, expected 0 x1", k, wr_data[k], wr_hits[k]);
      end
    end
    vectors++;
    if (!got || active_count !== 7'd0 || wr_cnt != N_ELEM) begin
      miscompares++;
      $display("FAIL neg_summary: got cnt=%0d writes=%0d done=%0d, expected 0 64 1", active_count, wr_cnt, got);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < N_ELEM; k++) mem[k] = {DATA_W{1'b0}};
    test_reset();
    test_ramp();
    test_boundary();
    test_random();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_all_negative();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
